// File: rtl/fp_issue_stage.sv
// FP issue stage: holds one decoded FP instruction, resolves its operands
// from register status / ROB / RF, and dispatches to ROB and RS together.
module fp_issue_stage #(
  parameter int unsigned REG_NUM     = 32,
  parameter int unsigned FLEN        = 64,
  parameter int unsigned STALL_CNT_W = 16,
  parameter type         rob_idx_t   = logic [5:0],
  localparam int unsigned RegIdxLen  = $clog2(REG_NUM)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   flush_i,

  input  logic                   instr_valid_i,
  output logic                   instr_ready_o,
  input  logic [7:0]             instr_op_i,
  input  logic [RegIdxLen-1:0]   instr_rd_idx_i,
  input  logic [RegIdxLen-1:0]   instr_rs1_idx_i,
  input  logic [RegIdxLen-1:0]   instr_rs2_idx_i,
  input  logic [RegIdxLen-1:0]   instr_rs3_idx_i,

  output logic                   regstat_valid_o,
  output logic [RegIdxLen-1:0]   regstat_rd_idx_o,
  output logic [RegIdxLen-1:0]   regstat_rs1_idx_o,
  output logic [RegIdxLen-1:0]   regstat_rs2_idx_o,
  output logic [RegIdxLen-1:0]   regstat_rs3_idx_o,
  output rob_idx_t               regstat_rob_idx_o,
  input  logic                   regstat_rs1_busy_i,
  input  logic                   regstat_rs2_busy_i,
  input  logic                   regstat_rs3_busy_i,
  input  rob_idx_t               regstat_rs1_rob_idx_i,
  input  rob_idx_t               regstat_rs2_rob_idx_i,
  input  rob_idx_t               regstat_rs3_rob_idx_i,

  input  logic [FLEN-1:0]        rf_rs1_value_i,
  input  logic [FLEN-1:0]        rf_rs2_value_i,
  input  logic [FLEN-1:0]        rf_rs3_value_i,

  input  logic                   rob_rs1_ready_i,
  input  logic                   rob_rs2_ready_i,
  input  logic                   rob_rs3_ready_i,
  input  logic [FLEN-1:0]        rob_rs1_value_i,
  input  logic [FLEN-1:0]        rob_rs2_value_i,
  input  logic [FLEN-1:0]        rob_rs3_value_i,
  input  logic                   rob_ready_i,
  input  rob_idx_t               rob_tail_idx_i,
  output logic                   rob_valid_o,

  output logic                   rs_valid_o,
  input  logic                   rs_ready_i,
  output logic [7:0]             rs_op_o,
  output rob_idx_t               rs_rob_idx_o,
  output logic                   rs_rs1_ready_o,
  output logic                   rs_rs2_ready_o,
  output logic                   rs_rs3_ready_o,
  output rob_idx_t               rs_rs1_rob_idx_o,
  output rob_idx_t               rs_rs2_rob_idx_o,
  output rob_idx_t               rs_rs3_rob_idx_o,
  output logic [FLEN-1:0]        rs_rs1_value_o,
  output logic [FLEN-1:0]        rs_rs2_value_o,
  output logic [FLEN-1:0]        rs_rs3_value_o,

  output logic [STALL_CNT_W-1:0] stall_cnt_o
);

  typedef enum logic {
    EMPTY,
    HELD
  } state_e;

  typedef struct packed {
    logic [7:0]           op;
    logic [RegIdxLen-1:0] rd;
    logic [RegIdxLen-1:0] rs1;
    logic [RegIdxLen-1:0] rs2;
    logic [RegIdxLen-1:0] rs3;
  } issue_t;

  state_e                 state_q;
  issue_t                 issue_q;
  issue_t                 issue_d;
  logic [STALL_CNT_W-1:0] stall_q;
  logic                   held;
  logic                   fire;
  logic                   accept;

  assign held   = (state_q == HELD);
  assign fire   = held & rs_ready_i & rob_ready_i & ~flush_i;
  assign accept = instr_valid_i & instr_ready_o;

  assign instr_ready_o = ~flush_i & (~held | fire);

  assign issue_d = '{
    op:  instr_op_i,
    rd:  instr_rd_idx_i,
    rs1: instr_rs1_idx_i,
    rs2: instr_rs2_idx_i,
    rs3: instr_rs3_idx_i
  };

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= EMPTY;
      issue_q <= '0;
      stall_q <= '0;
    end else begin
      if (held && !fire && stall_q != '1) begin
        stall_q <= stall_q + 1'b1;
      end
      if (accept) begin
        issue_q <= issue_d;
      end
      if (flush_i) begin
        state_q <= EMPTY;
      end else if (accept) begin
        state_q <= HELD;
      end else if (fire) begin
        state_q <= EMPTY;
      end
    end
  end

  assign stall_cnt_o = stall_q;

  // ROB and RS each see valid only when the other side can also take it
  assign rs_valid_o      = held & rob_ready_i;
  assign rob_valid_o     = held & rs_ready_i;
  assign regstat_valid_o = fire;

  assign rs_op_o           = issue_q.op;
  assign regstat_rd_idx_o  = issue_q.rd;
  assign regstat_rs1_idx_o = issue_q.rs1;
  assign regstat_rs2_idx_o = issue_q.rs2;
  assign regstat_rs3_idx_o = issue_q.rs3;

  assign rs_rob_idx_o      = rob_tail_idx_i;
  assign regstat_rob_idx_o = rob_tail_idx_i;

  assign rs_rs1_rob_idx_o = regstat_rs1_rob_idx_i;
  assign rs_rs2_rob_idx_o = regstat_rs2_rob_idx_i;
  assign rs_rs3_rob_idx_o = regstat_rs3_rob_idx_i;

  function automatic logic [FLEN:0] resolve(
    input logic            busy,
    input logic            rob_rdy,
    input logic [FLEN-1:0] rf_val,
    input logic [FLEN-1:0] rob_val
  );
    logic [FLEN:0] r;
    r = '0;
    if (!busy) begin
      r = {1'b1, rf_val};
    end else if (rob_rdy) begin
      r = {1'b1, rob_val};
    end
    return r;
  endfunction

  assign {rs_rs1_ready_o, rs_rs1_value_o} = resolve(
    regstat_rs1_busy_i, rob_rs1_ready_i,
    rf_rs1_value_i, rob_rs1_value_i);

  assign {rs_rs2_ready_o, rs_rs2_value_o} = resolve(
    regstat_rs2_busy_i, rob_rs2_ready_i,
    rf_rs2_value_i, rob_rs2_value_i);

  assign {rs_rs3_ready_o, rs_rs3_value_o} = resolve(
    regstat_rs3_busy_i, rob_rs3_ready_i,
    rf_rs3_value_i, rob_rs3_value_i);

endmodule
